minmax_tracker: RTL and testbench

Windowed running minimum/maximum tracker for 4-bit unsigned samples. It sits directly downstream of the 4-bit `comparator`, which has outputs EQ and LT. It instantiates two comparators and uses their EQ/LT results to update registered extremes over a window of `N_SAMPLES` accepted samples. A valid/ready handshake sits on the input side, and a one-cycle `done` pulse marks a completed window.

---
 rtl/minmax_pkg.sv | 13 +
 rtl/comparator.sv | 14 +
 rtl/minmax_tracker.sv | 122 ++++++++++++
 tb/tb_minmax_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared definitions for the windowed min/max tracker: FSM state encoding
// and the sample width used by the comparators.
package minmax_pkg;

    localparam int MM_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comparator.sv
// 4-bit unsigned comparator: eq = (x == y), lt = (x < y).
module comparator
    import minmax_pkg::*;
(
    input  logic [MM_W-1:0] x,
    input  logic [MM_W-1:0] y,
    output logic            eq,
    output logic            lt
);

    assign eq = (x == y);
    assign lt = (x < y);

endmodule

// File: rtl/minmax_tracker.sv
// Windowed running min/max over N_SAMPLES accepted 4-bit samples, with a
// one-cycle done pulse. Optional tie counter enabled by MINMAX_EQ_COUNT_EN.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int N_SAMPLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MM_W-1:0] in_data,
    output logic [MM_W-1:0] min_val,
    output logic [MM_W-1:0] max_val,
    output logic [3:0]      cnt,
    output logic            busy,
`ifdef MINMAX_EQ_COUNT_EN
    output logic            done,
    output logic [3:0]      eq_cnt
`else
    output logic            done
`endif
);

    localparam logic [3:0] N_LAST = 4'(N_SAMPLES);

    state_t          state_reg, state_next;
    logic [MM_W-1:0] min_reg, min_next;
    logic [MM_W-1:0] max_reg, max_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            a_lt, b_lt;

    // A: is the new sample below the current minimum?
`ifdef MINMAX_EQ_COUNT_EN
    logic            a_eq;
    logic [3:0]      eq_reg, eq_next;

    comparator u_cmp_a (.x(in_data), .y(min_reg), .eq(a_eq), .lt(a_lt));
`else
    comparator u_cmp_a (.x(in_data), .y(min_reg), .eq(), .lt(a_lt));
`endif
    // B: is the current maximum below the new sample?
    comparator u_cmp_b (.x(max_reg), .y(in_data), .eq(), .lt(b_lt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            min_reg   <= '0;
            max_reg   <= '0;
            cnt_reg   <= '0;
`ifdef MINMAX_EQ_COUNT_EN
            eq_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            min_reg   <= min_next;
            max_reg   <= max_next;
            cnt_reg   <= cnt_next;
`ifdef MINMAX_EQ_COUNT_EN
            eq_reg    <= eq_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        max_next   = max_reg;
        cnt_next   = cnt_reg;
`ifdef MINMAX_EQ_COUNT_EN
        eq_next    = eq_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    min_next   = '0;
                    max_next   = '0;
                    cnt_next   = '0;
`ifdef MINMAX_EQ_COUNT_EN
                    eq_next    = '0;
`endif
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    cnt_next = cnt_reg + 4'd1;
                    // First sample seeds both extremes; comparator results are stale here.
                    if (cnt_reg == 4'd0) begin
                        min_next = in_data;
                        max_next = in_data;
`ifdef MINMAX_EQ_COUNT_EN
                        eq_next  = 4'd1;
`endif
                    end else begin
                        if (a_lt) min_next = in_data;
                        if (b_lt) max_next = in_data;
`ifdef MINMAX_EQ_COUNT_EN
                        if (a_lt)      eq_next = 4'd1;
                        else if (a_eq) eq_next = eq_reg + 4'd1;
`endif
                    end
                    if (cnt_next == N_LAST) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state_reg == RUN);
    assign busy     = (state_reg == RUN) || (state_reg == DONE);
    assign done     = (state_reg == DONE);
    assign min_val  = min_reg;
    assign max_val  = max_reg;
    assign cnt      = cnt_reg;
`ifdef MINMAX_EQ_COUNT_EN
    assign eq_cnt   = eq_reg;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: table windows, stalls, control
// edges, resets and random windows against a queue-based reference model.
module tb_minmax_tracker;

    typedef logic [7:0][3:0] win_t;
    typedef struct {
        win_t s;
        int   emin;
        int   emax;
        int   eeq;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, in_ready, busy, done;
    logic [3:0] in_data, min_val, max_val, cnt;
    logic       start1, valid1, ready1, busy1, done1;
    logic [3:0] data1, min1, max1, cnt1;
`ifdef MINMAX_EQ_COUNT_EN
    logic [3:0] eq_cnt, eq1;
`endif

    int checks = 0;
    int errors = 0;
    int hist[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    minmax_tracker #(.N_SAMPLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .min_val(min_val),
        .max_val(max_val), .cnt(cnt), .busy(busy),
`ifdef MINMAX_EQ_COUNT_EN
        .done(done), .eq_cnt(eq_cnt)
`else
        .done(done)
`endif
    );

    minmax_tracker #(.N_SAMPLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(valid1),
        .in_ready(ready1), .in_data(data1), .min_val(min1),
        .max_val(max1), .cnt(cnt1), .busy(busy1),
`ifdef MINMAX_EQ_COUNT_EN
        .done(done1), .eq_cnt(eq1)
`else
        .done(done1)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_min();
        int m = 16;
        foreach (hist[i]) if (hist[i] < m) m = hist[i];
        return (hist.size() == 0) ? 0 : m;
    endfunction

    function automatic int m_max();
        int m = 0;
        foreach (hist[i]) if (hist[i] > m) m = hist[i];
        return m;
    endfunction

    function automatic int m_eq();
        int m = m_min();
        int n = 0;
        foreach (hist[i]) if (hist[i] == m) n++;
        return n;
    endfunction

    function automatic win_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        win_t w;
        w[0] = 4'(a0); w[1] = 4'(a1); w[2] = 4'(a2); w[3] = 4'(a3);
        w[4] = 4'(a4); w[5] = 4'(a5); w[6] = 4'(a6); w[7] = 4'(a7);
        return w;
    endfunction

    // Entered and left at #1 after a rising edge, with the DUT in IDLE.
    task automatic run_window(input win_t w, input bit stall, input bit glitch, input string tag);
        hist.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_run_ready"}, int'(in_ready), 1);
        chk({tag, "_run_busy"},  int'(busy), 1);
        chk({tag, "_run_cnt0"},  int'(cnt), 0);
        chk({tag, "_run_min0"},  int'(min_val), 0);
        for (int i = 0; i < 8; i++) begin
            if (stall) begin
                repeat ($urandom_range(1, 3)) begin
                    in_valid = 1'b0;
                    in_data  = 4'($urandom_range(0, 15));
                    @(posedge clk); #1;
                    chk({tag, "_stall_cnt"}, int'(cnt), i);
                end
            end
            in_valid = 1'b1;
            in_data  = w[i];
            start    = glitch && (i == 3);
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            hist.push_back(int'(w[i]));
            chk({tag, "_cnt"},  int'(cnt), i + 1);
            chk({tag, "_min"},  int'(min_val), m_min());
            chk({tag, "_max"},  int'(max_val), m_max());
`ifdef MINMAX_EQ_COUNT_EN
            chk({tag, "_eq"},   int'(eq_cnt), m_eq());
`endif
            chk({tag, "_done"}, int'(done), (i == 7) ? 1 : 0);
        end
        chk({tag, "_done_ready"}, int'(in_ready), 0);
        chk({tag, "_done_busy"},  int'(busy), 1);
        start = glitch;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_idle_done"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_cnt"},  int'(cnt), 8);
        chk({tag, "_idle_min"},  int'(min_val), m_min());
        chk({tag, "_idle_max"},  int'(max_val), m_max());
        $display("window %s: min=%0d max=%0d cnt=%0d", tag, min_val, max_val, cnt);
    endtask

    initial begin
        tbl[0] = '{s: mk(5, 3, 9, 3, 12, 0, 7, 15), emin: 0, emax: 15, eeq: 1};
        tbl[1] = '{s: mk(6, 6, 6, 6, 6, 6, 6, 6),   emin: 6, emax: 6,  eeq: 8};
        tbl[2] = '{s: mk(4, 4, 2, 2, 2, 9, 2, 4),   emin: 2, emax: 9,  eeq: 4};
        tbl[3] = '{s: mk(1, 2, 3, 4, 5, 6, 7, 8),   emin: 1, emax: 8,  eeq: 1};

        // Reset with random inputs, then release and idle.
        rst_n = 1'b0; start1 = 1'b0; valid1 = 1'b0; data1 = 4'd0;
        repeat (4) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        chk("rst_min", int'(min_val), 0);
        chk("rst_max", int'(max_val), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(in_ready), 0);
`ifdef MINMAX_EQ_COUNT_EN
        chk("rst_eq", int'(eq_cnt), 0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("idle_busy", int'(busy), 0);
            chk("idle_cnt", int'(cnt), 0);
            chk("idle_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;

        // Fixed windows from the table.
        for (int v = 0; v < 4; v++) begin
            run_window(tbl[v].s, 1'b0, 1'b0, $sformatf("tbl%0d", v));
            chk("tbl_min", int'(min_val), tbl[v].emin);
            chk("tbl_max", int'(max_val), tbl[v].emax);
`ifdef MINMAX_EQ_COUNT_EN
            chk("tbl_eq", int'(eq_cnt), tbl[v].eeq);
`endif
        end

        run_window(tbl[0].s, 1'b1, 1'b0, "stall");
        chk("stall_min", int'(min_val), 0);
        chk("stall_max", int'(max_val), 15);

        run_window(tbl[0].s, 1'b0, 1'b1, "glitch");
        chk("glitch_min", int'(min_val), 0);

        for (int r = 0; r < 8; r++) begin
            win_t w;
            for (int i = 0; i < 8; i++) w[i] = 4'($urandom_range(0, 15));
            run_window(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $sformatf("rnd%0d", r));
        end

        // Mid-window asynchronous reset after three accepts.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(12 - i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_cnt3", int'(cnt), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_min", int'(min_val), 0);
        chk("mid_rst_max", int'(max_val), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_idle_busy", int'(busy), 0);
        run_window(tbl[3].s, 1'b0, 1'b0, "after_rst");
        chk("after_rst_min", int'(min_val), 1);
        chk("after_rst_max", int'(max_val), 8);

        // Single-sample window on the N_SAMPLES=1 instance.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("n1_ready", int'(ready1), 1);
        chk("n1_done_early", int'(done1), 0);
        valid1 = 1'b1;
        data1  = 4'd10;
        @(posedge clk); #1;
        valid1 = 1'b0;
        chk("n1_done", int'(done1), 1);
        chk("n1_min", int'(min1), 10);
        chk("n1_max", int'(max1), 10);
        chk("n1_cnt", int'(cnt1), 1);
        @(posedge clk); #1;
        chk("n1_done_end", int'(done1), 0);
        chk("n1_busy_end", int'(busy1), 0);
        $display("window n1: min=%0d max=%0d cnt=%0d", min1, max1, cnt1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
